ifid_queue: RTL

- Instruction queue between the fetch stage and the decode stage.
- Buffers fetched {PC, PC+4, instruction} triples so a decode stall does not drop in-flight fetches.
- Flushed on a control-flow redirect, i.e. when fetch asserts PC_Changed.
- Presents a NOP bubble to decode when empty.

---
 rtl/ifid_queue_if.sv | 25 ++
 rtl/ifid_queue.sv | 74 +++++++
 2 files changed

// File: rtl/ifid_queue_if.sv
// rtl/ifid_queue_if.sv - fetch/decode handshake bundle for the IF/ID instruction queue
interface ifid_queue_if;
   logic        IF_valid;
   logic        IF_ready;
   logic [31:0] IF_PC_add;
   logic [31:0] IF_PC_link;
   logic [31:0] IF_instr;
   logic        ID_valid;
   logic        ID_ready;
   logic [31:0] ID_PC_add;
   logic [31:0] ID_PC_link;
   logic [31:0] ID_instr;

   // master: the pipeline side driving fetch entries and decode acceptance
   modport master (
      output IF_valid, IF_PC_add, IF_PC_link, IF_instr, ID_ready,
      input  IF_ready, ID_valid, ID_PC_add, ID_PC_link, ID_instr
   );

   // slave: the queue itself
   modport slave (
      input  IF_valid, IF_PC_add, IF_PC_link, IF_instr, ID_ready,
      output IF_ready, ID_valid, ID_PC_add, ID_PC_link, ID_instr
   );
endinterface

// File: rtl/ifid_queue.sv
// rtl/ifid_queue.sv - circular IF/ID instruction queue with redirect flush and NOP bubble when empty
module ifid_queue #(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic                     CLK,
   input  logic                     RSTn,
   input  logic                     EN,
   input  logic                     FLUSH,
   ifid_queue_if.slave              bus,
   output logic [$clog2(DEPTH):0]   COUNT
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [31:0]   r_pc_add  [DEPTH];
   logic [31:0]   r_pc_link [DEPTH];
   logic [31:0]   r_instr   [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;

   // Ready/valid come only from the registered count, so no IF->ID combinational path exists.
   assign w_full  = (r_count == FULL_CNT);
   assign w_empty = (r_count == '0);
   assign w_push  = EN & bus.IF_valid & ~w_full  & ~FLUSH;
   assign w_pop   = EN & bus.ID_ready & ~w_empty & ~FLUSH;

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (FLUSH) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (EN) begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

   // Storage needs no reset: entries are only visible once counted.
   always_ff @(posedge CLK) begin
      if (RSTn && w_push) begin
         r_pc_add[r_wr_ptr]  <= bus.IF_PC_add;
         r_pc_link[r_wr_ptr] <= bus.IF_PC_link;
         r_instr[r_wr_ptr]   <= bus.IF_instr;
      end
   end

   assign bus.IF_ready   = ~w_full;
   assign bus.ID_valid   = ~w_empty;
   assign bus.ID_PC_add  = w_empty ? 32'h0     : r_pc_add[r_rd_ptr];
   assign bus.ID_PC_link = w_empty ? 32'h0     : r_pc_link[r_rd_ptr];
   assign bus.ID_instr   = w_empty ? NOP_INSTR : r_instr[r_rd_ptr];
   assign COUNT          = r_count;
endmodule
